// File: rtl/imm_alu_ctrl_seq_if.sv
// Control bus between the immediate-ALU sequencer and the datapath.
// The sequencer side (master) takes run/opcode and drives every strobe;
// the datapath/stimulus side (slave) is the mirror image.
interface imm_alu_ctrl_seq_if #(
  parameter int OPC_W = 5
);
  logic             run;
  logic [OPC_W-1:0] opcode;

  logic PCout, MARin, Read, MDRin, MDRout, IRin, PCin, IncPC;
  logic Grb, Gra, Rout, Rin, Yin, Cout, Zin, Zlowout;

  logic [1:0] alu_op;
  logic [2:0] step;
  logic       busy;
  logic       done;
  logic       illegal;

  modport master (
    input  run, opcode,
    output PCout, MARin, Read, MDRin, MDRout, IRin, PCin, IncPC,
    output Grb, Gra, Rout, Rin, Yin, Cout, Zin, Zlowout,
    output alu_op, step, busy, done, illegal
  );

  modport slave (
    output run, opcode,
    input  PCout, MARin, Read, MDRin, MDRout, IRin, PCin, IncPC,
    input  Grb, Gra, Rout, Rin, Yin, Cout, Zin, Zlowout,
    input  alu_op, step, busy, done, illegal
  );
endinterface

// File: rtl/imm_alu_ctrl_seq.sv
// Hard-wired control sequencer for andi/ori/addi.
// Steps fetch (T0..T2), decode and Y load (T3), ALU op (T4) and write-back (T5).
// Strobes decode from the state register only; illegal additionally looks at
// the live opcode during T3. T1 stretches for MEM_WAIT extra cycles.
module imm_alu_ctrl_seq #(
  parameter int               OPC_W    = 5,
  parameter int               MEM_WAIT = 1,
  parameter logic [OPC_W-1:0] OP_ANDI  = 5'b01100,
  parameter logic [OPC_W-1:0] OP_ORI   = 5'b01101,
  parameter logic [OPC_W-1:0] OP_ADDI  = 5'b01011
) (
  input logic                Clock,
  input logic                clear,
  imm_alu_ctrl_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state, state_nxt;
  logic [2:0] wait_cnt, wait_nxt;
  logic [1:0] op_q, op_nxt;
  logic       op_ok;
  logic [1:0] op_dec;

  // Map the opcode field onto the ALU function code; flag anything unsupported.
  always_comb begin
    op_ok  = 1'b1;
    op_dec = 2'b00;
    if (bus.opcode == OP_ANDI)      op_dec = 2'b00;
    else if (bus.opcode == OP_ORI)  op_dec = 2'b01;
    else if (bus.opcode == OP_ADDI) op_dec = 2'b10;
    else                            op_ok  = 1'b0;
  end

  // State, memory-wait counter and latched ALU function.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      op_q     <= 2'b00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      op_q     <= op_nxt;
    end
  end

  // Next-state logic and per-state strobes.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    op_nxt      = op_q;
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.PCin    = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Grb     = 1'b0;
    bus.Gra     = 1'b0;
    bus.Rout    = 1'b0;
    bus.Rin     = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.alu_op  = 2'b00;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    bus.step    = state;
    bus.busy    = (state != IDLE);

    case (state)
      IDLE: if (bus.run) state_nxt = T0;
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        state_nxt = T1;
      end
      T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        if (wait_cnt == WAIT_LAST) begin
          wait_nxt  = 3'd0;
          state_nxt = T2;
        end else begin
          wait_nxt  = wait_cnt + 3'd1;
        end
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        bus.PCin   = 1'b1;
        bus.IncPC  = 1'b1;
        state_nxt  = T3;
      end
      T3: begin
        bus.Grb  = 1'b1;
        bus.Rout = 1'b1;
        bus.Yin  = 1'b1;
        if (op_ok) begin
          op_nxt    = op_dec;
          state_nxt = T4;
        end else begin
          bus.illegal = 1'b1;
          state_nxt   = IDLE;
        end
      end
      T4: begin
        bus.Cout   = 1'b1;
        bus.Zin    = 1'b1;
        bus.alu_op = op_q;
        state_nxt  = T5;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        bus.Gra     = 1'b1;
        bus.Rin     = 1'b1;
        bus.done    = 1'b1;
        state_nxt   = bus.run ? T0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
